// File: rtl/button_pkg.sv
// ==== button_pkg: shared constants and types for the button conditioner. Rev 1.0 ====
`default_nettype none

package button_pkg;

  localparam int NUM_BTN    = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_CENTER = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

endpackage

`default_nettype wire

// File: rtl/button_debounce_bit.sv
// ==== button_debounce_bit: sync + debounce + press pulse for one button; ====
// ==== auto-repeat FSM compiled in with BUTTON_AUTOREPEAT_EN. Rev 1.0      ====
`default_nettype none

module button_debounce_bit
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 7500000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             accept_rise;
  logic             accept_fall;
  logic             repeat_fire;

  assign accept      = (sync2 != level) && (cnt == CNT_LAST);
  assign accept_rise = accept & sync2;
  assign accept_fall = accept & ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      press <= accept_rise | repeat_fire;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

      repeat_state_t    state;
      repeat_state_t    state_nxt;
      logic [RPT_W-1:0] rcnt;
      logic [RPT_W-1:0] rcnt_nxt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= IDLE;
          rcnt  <= '0;
        end else begin
          state <= state_nxt;
          rcnt  <= rcnt_nxt;
        end
      end

      // A release acceptance wins over a pulse falling due in the same cycle.
      always_comb begin
        state_nxt   = state;
        rcnt_nxt    = rcnt;
        repeat_fire = 1'b0;
        case (state)
          IDLE: begin
            if (accept_rise) begin
              rcnt_nxt  = RPT_W'(REPEAT_DELAY - 1);
              state_nxt = WAIT;
            end
          end
          WAIT, REPEAT: begin
            if (accept_fall) begin
              state_nxt = IDLE;
            end else if (rcnt == '0) begin
              repeat_fire = 1'b1;
              rcnt_nxt    = RPT_W'(REPEAT_PERIOD - 1);
              state_nxt   = REPEAT;
            end else begin
              rcnt_nxt = rcnt - RPT_W'(1);
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else begin : g_no_repeat
      assign repeat_fire = 1'b0;
    end
  endgenerate
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN};
  assign repeat_fire       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ==== button_conditioner: five-button debounce/press-pulse front end;    ====
// ==== define BUTTON_AUTOREPEAT_EN for held-button auto-repeat. Rev 1.0   ====
`default_nettype none

module button_conditioner
  import button_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 7500000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b11101
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press
);

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (REPEAT_MASK[i])
      ) u_bit (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw[i]),
        .level (btn_level[i]),
        .press (btn_press[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Input conditioning stage between the Mojo shield's five raw push-buttons and the tile-sort game logic. It synchronises each button, debounces it with a per-button stability counter, and emits a clean level plus a one-cycle press pulse per button. The tile-sort block consumes the pulses as its left/right/up/down/center move commands. Optionally, it auto-repeats held direction buttons.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); must be ≥2
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse
- REPEAT_PERIOD, 7500000, cycles between subsequent repeat pulses
- REPEAT_MASK, 5'b11101, buttons eligible for auto-repeat (center, bit 1, excluded)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- btn_raw  in  5  raw buttons, active-high; bit0 up, 1 center, 2 down, 3 left, 4 right
- btn_level  out  5  debounced level per button
- btn_press  out  5  one-cycle pulse per accepted press (or repeat)

## Operation
- Each of the 5 bits is handled identically and independently.
- Two-flop synchroniser per bit: sync1 ← btn_raw, sync2 ← sync1.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES):
  - When sync2 == btn_level, cnt ← 0.
  - When sync2 != btn_level and cnt < DEBOUNCE_CYCLES-1, cnt ← cnt+1.
  - When sync2 != btn_level and cnt == DEBOUNCE_CYCLES-1, btn_level ← sync2 and cnt ← 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles clears cnt and never changes btn_level.
- btn_press is registered. It is 1 for exactly the cycle in which btn_level first reads 1 after a 0→1 acceptance.
- Release (1→0) produces no pulse.
- Repeat FSM per bit, 2-bit state:
  - IDLE: on a press acceptance, load rcnt ← REPEAT_DELAY-1 and go to WAIT.
  - WAIT: decrement rcnt each cycle. At rcnt == 0, pulse btn_press, load rcnt ← REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: same decrement. At rcnt == 0, pulse and reload REPEAT_PERIOD-1.
  - Any release acceptance forces IDLE with no pulse.
  - Bits with REPEAT_MASK=0 stay in IDLE.
- Width of rcnt is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It never wraps: reload always happens at 0.

## Timing
- Reset (rst_n low, asynchronous): sync1, sync2, cnt, rcnt, FSM state, btn_level and btn_press all go to 0/IDLE immediately.
- Reset asserted mid-debounce or mid-repeat discards all progress. A button held through reset release is accepted as a fresh press after the normal latency.
- Latency: btn_raw rises before edge E and stays stable. sync2 is 1 after edge E+1. btn_level and btn_press rise after edge E+1+DEBOUNCE_CYCLES. btn_press falls one edge later.
- Release latency is identical for btn_level.
- First repeat pulse: REPEAT_DELAY cycles after the press pulse. Following repeat pulses: every REPEAT_PERIOD cycles.
- Simultaneous events on different bits are independent; multiple btn_press bits may be high in the same cycle.
- Minimum spacing between pulses on one bit: DEBOUNCE_CYCLES*2 (press–release–press) or REPEAT_PERIOD.

## Configuration
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined: repeat FSM and rcnt are compiled in, as described above.
- Undefined: no repeat logic is instantiated. REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK are ignored. btn_press pulses only on debounce acceptance.

## Structure
- Shared package `button_pkg`:
  - button index constants BTN_UP=0, BTN_CENTER=1, BTN_DOWN=2, BTN_LEFT=3, BTN_RIGHT=4
  - NUM_BTN=5
  - repeat state typedef {IDLE, WAIT, REPEAT}
- Sub-module `button_debounce_bit`: synchroniser, debounce counter, edge detector and the optional repeat FSM for one bit.
- Top instantiates `button_debounce_bit` NUM_BTN times via generate.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Reset: rst_n low with btn_raw=5'b11111 → btn_level=0, btn_press=0 throughout. After release, btn_level=5'b11111 exactly 5 edges later with one press pulse per bit.
- Clean press of bit 3 (left), held 20 cycles, macro undefined → btn_level[3] rises 5 edges after raw rises; btn_press[3] high exactly 1 cycle; no further pulses; btn_level[3] falls 5 edges after raw falls.
- Glitch: bit 0 high for 3 cycles then low → btn_level and btn_press stay 0.
- Bounce: bit 4 toggles 1,0,1,0,1 on successive cycles then holds 1 → exactly one btn_press[4] pulse, 5 edges after the final rise.
- Auto-repeat (macro defined), bit 2 held 30 cycles after acceptance → pulses at acceptance, +10, +15, +20, +25. Bit 1 held the same way → one pulse only.
- Async reset mid-repeat: rst_n low between two pulses → outputs 0 immediately; no pulse until re-accepted after release of reset.
